// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared state encodings and trigger-mode constants for the capture sequencer
package la_pkg;

  localparam int LA_STATE_W = 3;

  typedef enum logic [LA_STATE_W-1:0] {
    LA_IDLE    = 3'd0,
    LA_ARMED   = 3'd1,
    LA_DELAY   = 3'd2,
    LA_CAPTURE = 3'd3,
    LA_DONE    = 3'd4
  } la_state_e;

  localparam logic [1:0] LA_TRIG_RISE  = 2'b00;
  localparam logic [1:0] LA_TRIG_FALL  = 2'b01;
  localparam logic [1:0] LA_TRIG_BOTH  = 2'b10;
  localparam logic [1:0] LA_TRIG_LEVEL = 2'b11;

endpackage

// File: rtl/la_trig_qualify.sv
// rtl/la_trig_qualify.sv - trigger edge/level qualification against the previous trigger sample
module la_trig_qualify
  import la_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       trig_in,
  input  logic [1:0] trig_mode,
  output logic       qualified
);

  logic trig_prev_q;
  logic trig_prev_d;

  always_comb trig_prev_d = trig_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_prev_q <= 1'b0;
    else     trig_prev_q <= trig_prev_d;
  end

  always_comb begin
    qualified = 1'b0;
    case (trig_mode)
      LA_TRIG_RISE:  qualified = trig_in & ~trig_prev_q;
      LA_TRIG_FALL:  qualified = ~trig_in & trig_prev_q;
      LA_TRIG_BOTH:  qualified = trig_in ^ trig_prev_q;
      LA_TRIG_LEVEL: qualified = trig_in;
      default:       qualified = 1'b0;
    endcase
  end

endmodule

// File: rtl/la_capture_sequencer.sv
// rtl/la_capture_sequencer.sv - arm/trigger/delay/capture/done sequencer driving the sample window
module la_capture_sequencer
  import la_pkg::*;
#(
  parameter int pCAPTURE_DEPTH = 1024,
  parameter int pCOUNT_WIDTH   = 10,
  parameter int pDELAY_WIDTH   = 16
) (
  input  logic                    observer_clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    trig_in,
  input  logic [1:0]              trig_mode,
  input  logic [pDELAY_WIDTH-1:0] delay,
  input  logic [pCOUNT_WIDTH-1:0] length,
  input  logic                    auto_rearm,
  input  logic                    done_ack,
  output logic                    capture_go,
  output logic                    capture_en,
  output logic [pCOUNT_WIDTH-1:0] sample_count,
  output logic [LA_STATE_W-1:0]   state,
  output logic                    done,
  output logic                    overrun
);

  localparam logic [pCOUNT_WIDTH-1:0] MAX_LEN = pCOUNT_WIDTH'(pCAPTURE_DEPTH - 1);

  la_state_e               state_q, state_d;
  logic [pDELAY_WIDTH-1:0] delay_cfg_q, delay_cfg_d;
  logic [pDELAY_WIDTH-1:0] delay_cnt_q, delay_cnt_d;
  logic [pCOUNT_WIDTH-1:0] len_q, len_d;
  logic [1:0]              mode_q, mode_d;
  logic [pCOUNT_WIDTH-1:0] sample_count_q, sample_count_d;
  logic                    capture_go_q, capture_go_d;
  logic                    capture_en_q, capture_en_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;
  logic                    qualified;
  logic                    arm_accept;

  la_trig_qualify u_trig_qualify (
    .clk       (observer_clk),
    .rst       (reset),
    .trig_in   (trig_in),
    .trig_mode (mode_q),
    .qualified (qualified)
  );

  // arm is only honoured from IDLE or DONE, and never alongside abort
  assign arm_accept = arm && !abort && (state_q == LA_IDLE || state_q == LA_DONE);

  always_ff @(posedge observer_clk or posedge reset) begin
    if (reset) begin
      state_q        <= LA_IDLE;
      delay_cfg_q    <= '0;
      delay_cnt_q    <= '0;
      len_q          <= '0;
      mode_q         <= '0;
      sample_count_q <= '0;
      capture_go_q   <= 1'b0;
      capture_en_q   <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      delay_cfg_q    <= delay_cfg_d;
      delay_cnt_q    <= delay_cnt_d;
      len_q          <= len_d;
      mode_q         <= mode_d;
      sample_count_q <= sample_count_d;
      capture_go_q   <= capture_go_d;
      capture_en_q   <= capture_en_d;
      done_q         <= done_d;
      overrun_q      <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = LA_IDLE;
    end else begin
      case (state_q)
        LA_IDLE:    if (arm) state_d = LA_ARMED;
        LA_ARMED:   if (qualified) state_d = (delay_cfg_q != '0) ? LA_DELAY : LA_CAPTURE;
        LA_DELAY:   if (delay_cnt_q == '0) state_d = LA_CAPTURE;
        LA_CAPTURE: if (sample_count_q == len_q) state_d = LA_DONE;
        LA_DONE: begin
          if (arm)           state_d = LA_ARMED;
          else if (done_ack) state_d = auto_rearm ? LA_ARMED : LA_IDLE;
        end
        default:    state_d = LA_IDLE;
      endcase
    end
  end

  always_comb begin
    delay_cfg_d    = arm_accept ? delay : delay_cfg_q;
    mode_d         = arm_accept ? trig_mode : mode_q;
    len_d          = len_q;
    if (arm_accept) len_d = (length > MAX_LEN) ? MAX_LEN : length;

    // loaded with delay-1 so the DELAY state lasts exactly delay cycles
    delay_cnt_d = delay_cnt_q;
    if (state_q == LA_ARMED && state_d == LA_DELAY)
      delay_cnt_d = delay_cfg_q - pDELAY_WIDTH'(1);
    else if (state_q == LA_DELAY && delay_cnt_q != '0)
      delay_cnt_d = delay_cnt_q - pDELAY_WIDTH'(1);

    sample_count_d = '0;
    if (state_q == LA_CAPTURE && state_d == LA_CAPTURE)
      sample_count_d = sample_count_q + pCOUNT_WIDTH'(1);

    capture_en_d = (state_d == LA_CAPTURE);
    capture_go_d = (state_d == LA_CAPTURE) && (state_q != LA_CAPTURE);
    done_d       = (state_d == LA_DONE);

    overrun_d = overrun_q;
    if (arm_accept)
      overrun_d = 1'b0;
    else if (qualified && (state_q == LA_DELAY || state_q == LA_CAPTURE))
      overrun_d = 1'b1;
  end

  assign capture_go   = capture_go_q;
  assign capture_en   = capture_en_q;
  assign sample_count = sample_count_q;
  assign state        = state_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_la_capture_sequencer.sv
// tb/tb_la_capture_sequencer.sv - directed self-checking bench for la_capture_sequencer
module tb_la_capture_sequencer;

  logic        observer_clk;
  logic        reset;
  logic        arm;
  logic        abort;
  logic        trig_in;
  logic [1:0]  trig_mode;
  logic [15:0] delay;
  logic [9:0]  length;
  logic        auto_rearm;
  logic        done_ack;
  logic        capture_go;
  logic        capture_en;
  logic [9:0]  sample_count;
  logic [2:0]  state;
  logic        done;
  logic        overrun;

  int n_assert = 0;
  int n_fail   = 0;

  la_capture_sequencer #(
    .pCAPTURE_DEPTH (512),
    .pCOUNT_WIDTH   (10),
    .pDELAY_WIDTH   (16)
  ) dut (
    .observer_clk (observer_clk),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .trig_in      (trig_in),
    .trig_mode    (trig_mode),
    .delay        (delay),
    .length       (length),
    .auto_rearm   (auto_rearm),
    .done_ack     (done_ack),
    .capture_go   (capture_go),
    .capture_en   (capture_en),
    .sample_count (sample_count),
    .state        (state),
    .done         (done),
    .overrun      (overrun)
  );

  initial observer_clk = 1'b0;
  always #5 observer_clk = ~observer_clk;

  task automatic tick();
    @(posedge observer_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [9:0] last;

    reset = 1'b1; arm = 0; abort = 0; trig_in = 0; trig_mode = 2'b00;
    delay = '0; length = '0; auto_rearm = 0; done_ack = 0;
    #2;
    chk("reset_state", state, 0);
    chk("reset_go", capture_go, 0);
    chk("reset_en", capture_en, 0);
    chk("reset_cnt", sample_count, 0);
    chk("reset_done", done, 0);
    chk("reset_ovr", overrun, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // rising, delay 0, length 7
    arm = 1; trig_mode = 2'b00; delay = 0; length = 7;
    tick();
    arm = 0;
    chk("t1_armed", state, 1);
    tick(); tick();
    chk("t1_wait", state, 1);
    trig_in = 1;
    tick();
    chk("t1_state_cap", state, 3);
    chk("t1_go", capture_go, 1);
    chk("t1_en0", capture_en, 1);
    chk("t1_cnt0", sample_count, 0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("t1_go_once", capture_go, 0);
      chk("t1_en", capture_en, 1);
      chk("t1_cnt", sample_count, i);
    end
    tick();
    chk("t1_en_off", capture_en, 0);
    chk("t1_done", done, 1);
    chk("t1_state_done", state, 4);
    tick();
    chk("t1_done_hold", done, 1);
    done_ack = 1;
    tick();
    done_ack = 0;
    chk("t1_ack_done", done, 0);
    chk("t1_ack_idle", state, 0);

    // falling, delay 5, length 3
    trig_in = 0;
    tick();
    arm = 1; trig_mode = 2'b01; delay = 5; length = 3;
    tick();
    arm = 0;
    chk("t2_armed", state, 1);
    trig_in = 1;
    tick();
    chk("t2_rise_ignored", state, 1);
    tick();
    chk("t2_rise_ignored2", state, 1);
    trig_in = 0;
    tick();
    chk("t2_delay", state, 2);
    chk("t2_go_early", capture_go, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_delay_hold", state, 2);
      chk("t2_en_early", capture_en, 0);
    end
    tick();
    chk("t2_go", capture_go, 1);
    chk("t2_cap", state, 3);
    tick(); tick(); tick();
    chk("t2_cnt_last", sample_count, 3);
    chk("t2_en_last", capture_en, 1);
    tick();
    chk("t2_done", done, 1);
    chk("t2_ovr", overrun, 0);
    done_ack = 1;
    tick();
    done_ack = 0;
    chk("t2_idle", state, 0);

    // overrun: second rising edge during DELAY
    arm = 1; trig_mode = 2'b00; delay = 3; length = 2;
    tick();
    arm = 0;
    trig_in = 1;
    tick();
    chk("t3_delay", state, 2);
    trig_in = 0;
    tick();
    chk("t3_ovr_clear", overrun, 0);
    trig_in = 1;
    tick();
    chk("t3_ovr_set", overrun, 1);
    chk("t3_delay_end", state, 2);
    tick();
    chk("t3_go", capture_go, 1);
    tick(); tick(); tick();
    chk("t3_done", done, 1);
    chk("t3_ovr_done", overrun, 1);
    done_ack = 1;
    tick();
    done_ack = 0;
    chk("t3_ovr_ack", overrun, 1);
    chk("t3_idle", state, 0);

    // abort with arm in same cycle, then mid-capture abort
    arm = 1; abort = 1; trig_mode = 2'b00; delay = 0; length = 7;
    tick();
    arm = 0; abort = 0;
    chk("t4_abort_arm_state", state, 0);
    chk("t4_abort_arm_ovr", overrun, 1);
    arm = 1;
    tick();
    arm = 0;
    chk("t4_arm", state, 1);
    chk("t4_arm_clr_ovr", overrun, 0);
    trig_in = 0;
    tick();
    trig_in = 1;
    tick();
    chk("t4_go", capture_go, 1);
    tick(); tick();
    chk("t4_cnt2", sample_count, 2);
    abort = 1;
    tick();
    abort = 0;
    chk("t4_abort_idle", state, 0);
    chk("t4_abort_en", capture_en, 0);
    chk("t4_abort_done", done, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("t4_no_done", done, 0);
    chk("t4_still_idle", state, 0);

    // clamp: length 1023 limited to 511 with depth 512, level mode
    arm = 1; trig_mode = 2'b11; delay = 0; length = 10'd1023;
    tick();
    arm = 0;
    chk("t5_armed", state, 1);
    tick();
    chk("t5_go", capture_go, 1);
    n = 0; last = '0;
    for (int i = 0; i < 600 && capture_en === 1'b1; i++) begin
      n++;
      last = sample_count;
      tick();
    end
    chk("t5_en_cycles", n, 512);
    chk("t5_last_cnt", last, 511);
    chk("t5_done", done, 1);

    // arm in DONE, auto re-arm with level trigger held high
    arm = 1; trig_mode = 2'b11; delay = 0; length = 2; auto_rearm = 1;
    tick();
    arm = 0;
    chk("t6_rearm_state", state, 1);
    chk("t6_rearm_done", done, 0);
    tick();
    chk("t6_go", capture_go, 1);
    tick(); tick();
    chk("t6_cnt2", sample_count, 2);
    tick();
    chk("t6_done", done, 1);
    done_ack = 1;
    tick();
    done_ack = 0;
    chk("t6_ack_armed", state, 1);
    chk("t6_ack_done", done, 0);
    chk("t6_ack_go", capture_go, 0);
    tick();
    chk("t6_b2b_go", capture_go, 1);
    tick(); tick();
    chk("t6_b2b_cnt", sample_count, 2);
    tick();
    chk("t6_b2b_done", done, 1);
    auto_rearm = 0; done_ack = 1;
    tick();
    done_ack = 0;
    chk("t6_idle", state, 0);

    // asynchronous reset mid-capture
    arm = 1; trig_mode = 2'b11; delay = 0; length = 20;
    tick();
    arm = 0;
    tick(); tick(); tick();
    chk("t7_capturing", capture_en, 1);
    #3;
    reset = 1;
    #1;
    chk("t7_rst_state", state, 0);
    chk("t7_rst_en", capture_en, 0);
    chk("t7_rst_cnt", sample_count, 0);
    tick();
    reset = 0;
    for (int i = 0; i < 30; i++) tick();
    chk("t7_no_done", done, 0);
    chk("t7_idle", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
